// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, drives the instruction-memory read
// address and registers the returned word for decode.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | fetching; stall holds, redirect reloads the PC with a one-bubble flush
// FAULT | an illegal PC was fetched; everything frozen until clear
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter int unsigned TEXT_WORDS = 256
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_instr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  // One extra bit so a segment ending exactly at 2^32 still compares correctly.
  localparam logic [32:0] TEXT_END = {1'b0, TEXT_BASE} + (33'(TEXT_WORDS) * 33'd4);

  typedef enum logic {
    RUN,
    FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        pc_legal;

  assign pc_legal    = (pc[1:0] == 2'b00) && (pc >= TEXT_BASE) && ({1'b0, pc} < TEXT_END);
  assign mem_address = pc;

  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= RUN;
      pc           <= RESET_PC;
      instr_out    <= 32'd0;
      pc_out       <= 32'd0;
      pc_plus4_out <= 32'd0;
      valid_out    <= 1'b0;
      fault        <= 1'b0;
      fault_pc     <= 32'd0;
      fetch_count  <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            // The target is checked on the next cycle through pc_legal.
            pc        <= redirect_target;
            valid_out <= 1'b0;
          end else if (!pc_legal) begin
            state     <= FAULT;
            fault     <= 1'b1;
            fault_pc  <= pc;
            valid_out <= 1'b0;
          end else if (!stall) begin
            instr_out    <= mem_instr;
            pc_out       <= pc;
            pc_plus4_out <= pc + 32'd4;
            valid_out    <= 1'b1;
            pc           <= pc + 32'd4;
            fetch_count  <= fetch_count + 32'd1;
          end
        end
        FAULT: begin
          valid_out <= 1'b0;
        end
        default: begin
          state <= FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the single-cycle/pipelined datapath. Owns the PC, drives the instruction-memory read address, and registers the returned word into an IF/ID-style output register.
- Supports stall, branch/jump redirect with flush, fault detection on out-of-segment or misaligned fetch, and a count of delivered instructions.
- Sits between the instruction memory (combinational read: address in, word out in the same cycle) and decode.

Parameters:
- RESET_PC, 32'h00400000, PC value loaded on clear.
- TEXT_BASE, 32'h00400000, lowest legal fetch address.
- TEXT_WORDS, 256, number of 32-bit words in the text segment; legal range is [TEXT_BASE, TEXT_BASE + 4*TEXT_WORDS).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- clear  in  1  reset; synchronous, active-high.
- stall  in  1  downstream not ready: hold PC and output register.
- redirect  in  1  load redirect_target into PC and flush.
- redirect_target  in  32  new fetch address (branch/jump target).
- mem_address  out  32  read address to instruction memory; equals the PC register.
- mem_instr  in  32  word returned by instruction memory for mem_address (same cycle).
- instr_out  out  32  registered instruction to decode.
- pc_out  out  32  address of instr_out.
- pc_plus4_out  out  32  pc_out + 4, for branch and link arithmetic.
- valid_out  out  1  instr_out/pc_out hold a real instruction.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  offending address, captured on fault entry.
- fetch_count  out  32  number of instructions delivered (valid_out rising or advancing).

Behaviour:
- Clear: synchronous, highest priority over every other input.
  - pc <= RESET_PC; instr_out, pc_out, pc_plus4_out, fault_pc, fetch_count <= 0; valid_out, fault <= 0; state <= RUN.
- States: RUN, FAULT. Stall is a hold condition within RUN, not a separate state.
- Legal fetch address:
  - (addr[1:0] == 0) and TEXT_BASE <= addr < TEXT_BASE + 4*TEXT_WORDS.
  - The comparison is unsigned 32-bit.
- Priority each cycle in RUN: clear > redirect > illegal PC > stall > advance.
- Redirect:
  - pc <= redirect_target; valid_out <= 0, a one-bubble flush.
  - instr_out and pc_out hold their values; fetch_count is unchanged.
  - Redirect overrides stall in the same cycle.
  - An illegal target is not faulted at redirect time. It faults on the following cycle via the illegal-PC rule.
- Illegal PC (pc itself illegal, no redirect):
  - state <= FAULT; fault <= 1; fault_pc <= pc; valid_out <= 0.
  - mem_instr is ignored.
- Stall (pc legal, no redirect): pc, instr_out, pc_out, pc_plus4_out, valid_out and fetch_count all hold.
- Advance (pc legal, no stall, no redirect):
  - instr_out <= mem_instr; pc_out <= pc; pc_plus4_out <= pc + 4; valid_out <= 1.
  - pc <= pc + 4, with 32-bit wrap and no saturation; fetch_count <= fetch_count + 1.
- Latency:
  - The word at address A appears on instr_out one cycle after mem_address == A with no stall.
  - Throughput is 1 instruction per cycle.
- End of segment:
  - After fetching the last word (TEXT_BASE + 4*TEXT_WORDS - 4), pc becomes out of range.
  - The next cycle enters FAULT with fault_pc = TEXT_BASE + 4*TEXT_WORDS.
  - The last word itself is delivered normally.
- FAULT state:
  - All registers hold; valid_out = 0; stall and redirect are ignored.
  - mem_address keeps driving the faulting PC.
  - Exit only via clear.
- Clear mid-operation (during stall, redirect or FAULT): the next cycle shows the full reset values; the in-flight instruction is dropped.

Test Plan:
- Reset and sequential fetch: clear for 2 cycles with memory preloaded 0x00221820, 0x00221822, 0x00221824.
  - Required: mem_address = 0x00400000 during clear.
  - Cycles 1..3 after release: instr_out = 0x00221820/0x00221822/0x00221824 with pc_out = 0x00400000/0x00400004/0x00400008, valid_out = 1, fetch_count = 1/2/3.
- Stall: assert stall for 3 cycles after the second delivery.
  - Required: instr_out stays 0x00221822, pc_out stays 0x00400004, mem_address stays 0x00400008, fetch_count stays 2.
  - After release, the next delivery is 0x00221824 at 0x00400008.
- Redirect with simultaneous stall: after delivering word 6 (pc_out 0x00400018), assert redirect with target 0x00400000 and stall=1.
  - Required: next cycle valid_out = 0 and mem_address = 0x00400000.
  - The following cycle delivers 0x00221820 at 0x00400000.
- Misaligned redirect: redirect_target = 0x00400006.
  - Required: one cycle later fault = 1, fault_pc = 0x00400006, valid_out = 0.
  - Later redirect to 0x00400000 is ignored and fault stays 1.
- End of segment: free-run from reset with TEXT_WORDS = 256.
  - Required: last valid delivery has pc_out = 0x004003FC and fetch_count = 256.
  - Next cycle fault = 1, fault_pc = 0x00400400.
- Clear in FAULT and mid-stream: assert clear while fault = 1, and separately while stall = 1.
  - Required: the next cycle shows fault = 0, valid_out = 0, fetch_count = 0, mem_address = 0x00400000.
  - The first delivery after release is 0x00221820.
